// File: rtl/array_struct_type_vertex_criterion_merge_bus.sv
// Merges four per-criterion vertex lanes into one struct-type-tagged stream.
// Optional: define VERTEX_CRITERION_MERGE_FIXED_PRIORITY_EN for fixed priority (lane 3 highest).
module array_struct_type_vertex_criterion_merge_bus #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BUS_WIDTH  = 4,
  parameter int unsigned SEL_WIDTH  = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                             clock,
  input  logic                             rstn,
  input  logic [SEL_WIDTH-1:0]             default_sel_in,
  input  logic [DATA_WIDTH*BUS_WIDTH-1:0]  data_in,
  input  logic [BUS_WIDTH-1:0]             data_in_valid,
  output logic [BUS_WIDTH-1:0]             data_in_ready,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic [SEL_WIDTH-1:0]             sel_out,
  output logic                             data_out_valid,
  input  logic                             data_out_ready,
  output logic [BUS_WIDTH-1:0]             overflow_sticky
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] READY_LIMIT = CW'(FIFO_DEPTH - 1);

  localparam logic [SEL_WIDTH-1:0] STRUCT_INVALID            = '1;
  localparam logic [SEL_WIDTH-1:0] VERTEX_VALUE_HOT_U32      = SEL_WIDTH'(32'h0000_0011);
  localparam logic [SEL_WIDTH-1:0] VERTEX_CACHE_WARM_U32     = SEL_WIDTH'(32'h0000_0012);
  localparam logic [SEL_WIDTH-1:0] VERTEX_VALUE_LUKEWARM_U32 = SEL_WIDTH'(32'h0000_0013);

  logic [DATA_WIDTH-1:0] r_mem    [BUS_WIDTH][FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr [BUS_WIDTH];
  logic [PW-1:0]         r_rd_ptr [BUS_WIDTH];
  logic [CW-1:0]         r_count  [BUS_WIDTH];
  logic [BUS_WIDTH-1:0]  r_ready;
  logic [BUS_WIDTH-1:0]  r_ovf;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [SEL_WIDTH-1:0]  r_sel;

  logic [DATA_WIDTH-1:0] w_lane_data [BUS_WIDTH];
  logic [CW-1:0]         w_count_d   [BUS_WIDTH];
  logic [BUS_WIDTH-1:0]  w_push;
  logic [BUS_WIDTH-1:0]  w_avail;
  logic [BUS_WIDTH-1:0]  w_take;
  logic [BUS_WIDTH-1:0]  w_fifo_pop;
  logic [BUS_WIDTH-1:0]  w_fifo_wr;
  logic                  w_load;
  logic                  w_any;
  logic [1:0]            w_grant;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [SEL_WIDTH-1:0]  w_head_sel;

  // A lane pushing into an empty FIFO is already a candidate, giving one-cycle latency.
  always_comb begin
    for (int i = 0; i < BUS_WIDTH; i++) begin
      w_lane_data[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
      w_push[i]      = data_in_valid[i] & r_ready[i];
      w_avail[i]     = (r_count[i] != '0) | w_push[i];
    end
  end

`ifdef VERTEX_CRITERION_MERGE_FIXED_PRIORITY_EN
  always_comb begin
    w_any   = 1'b0;
    w_grant = 2'd0;
    for (int i = 0; i < BUS_WIDTH; i++) begin
      if (w_avail[i]) begin
        w_any   = 1'b1;
        w_grant = 2'(i);
      end
    end
  end
`else
  logic [1:0] r_rr_ptr;
  logic [1:0] w_rr_idx;

  // Scan farthest-first so the lane nearest rr_ptr is the final winner.
  always_comb begin
    w_any    = 1'b0;
    w_grant  = 2'd0;
    w_rr_idx = 2'd0;
    for (int k = BUS_WIDTH - 1; k >= 0; k--) begin
      w_rr_idx = r_rr_ptr + 2'(k);
      if (w_avail[w_rr_idx]) begin
        w_any   = 1'b1;
        w_grant = w_rr_idx;
      end
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_rr_ptr <= 2'd0;
    end else if (w_load && w_any) begin
      r_rr_ptr <= w_grant + 2'd1;
    end
  end
`endif

  always_comb begin
    w_load = ~r_valid | data_out_ready;
    for (int i = 0; i < BUS_WIDTH; i++) begin
      w_take[i]     = w_load & w_any & (w_grant == 2'(i));
      w_fifo_pop[i] = w_take[i] & (r_count[i] != '0);
      // A bypassed beat goes straight to the output and never occupies the FIFO.
      w_fifo_wr[i]  = w_push[i] & ~(w_take[i] & (r_count[i] == '0));
      w_count_d[i]  = r_count[i] + CW'(w_fifo_wr[i]) - CW'(w_fifo_pop[i]);
    end
  end

  always_comb begin
    if (r_count[w_grant] != '0) begin
      w_head_data = r_mem[w_grant][r_rd_ptr[w_grant]];
    end else begin
      w_head_data = w_lane_data[w_grant];
    end
    case (w_grant)
      2'd3:    w_head_sel = VERTEX_VALUE_HOT_U32;
      2'd2:    w_head_sel = VERTEX_CACHE_WARM_U32;
      2'd1:    w_head_sel = VERTEX_VALUE_LUKEWARM_U32;
      default: w_head_sel = default_sel_in;
    endcase
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < BUS_WIDTH; i++) begin
      if (w_fifo_wr[i]) begin
        r_mem[i][r_wr_ptr[i]] <= w_lane_data[i];
      end
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < BUS_WIDTH; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_count[i]  <= '0;
      end
      r_ready <= '1;
      r_ovf   <= '0;
    end else begin
      for (int i = 0; i < BUS_WIDTH; i++) begin
        if (w_fifo_wr[i]) begin
          r_wr_ptr[i] <= r_wr_ptr[i] + PW'(1);
        end
        if (w_fifo_pop[i]) begin
          r_rd_ptr[i] <= r_rd_ptr[i] + PW'(1);
        end
        r_count[i] <= w_count_d[i];
        r_ready[i] <= (w_count_d[i] < READY_LIMIT);
        if (data_in_valid[i] && !r_ready[i]) begin
          r_ovf[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= STRUCT_INVALID;
    end else if (w_load) begin
      if (w_any) begin
        r_valid <= 1'b1;
        r_data  <= w_head_data;
        r_sel   <= w_head_sel;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_in_ready   = r_ready;
  assign data_out        = r_data;
  assign sel_out         = r_sel;
  assign data_out_valid  = r_valid;
  assign overflow_sticky = r_ovf;

endmodule

// File: tb/tb_array_struct_type_vertex_criterion_merge_bus.sv
// Self-checking bench for the vertex-criterion merge bus: scenario tasks plus a
// queue-based reference model stepped once per clock.
module tb_array_struct_type_vertex_criterion_merge_bus;

  localparam int DW    = 32;
  localparam int BW    = 4;
  localparam int SW    = 32;
  localparam int DEPTH = 4;

  localparam logic [31:0] STRUCT_INVALID = 32'hFFFF_FFFF;
  localparam logic [31:0] TAG_HOT        = 32'h0000_0011;
  localparam logic [31:0] TAG_WARM       = 32'h0000_0012;
  localparam logic [31:0] TAG_LUKEWARM   = 32'h0000_0013;

  logic            clock = 1'b0;
  logic            rstn;
  logic [SW-1:0]   default_sel_in;
  logic [DW*BW-1:0] data_in;
  logic [BW-1:0]   data_in_valid;
  logic [BW-1:0]   data_in_ready;
  logic [DW-1:0]   data_out;
  logic [SW-1:0]   sel_out;
  logic            data_out_valid;
  logic            data_out_ready;
  logic [BW-1:0]   overflow_sticky;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] m_q [4][$];
  logic        m_valid;
  logic [31:0] m_data;
  logic [31:0] m_sel;
  int          m_rr;
  logic [3:0]  m_ovf;

  array_struct_type_vertex_criterion_merge_bus #(
    .DATA_WIDTH(DW), .BUS_WIDTH(BW), .SEL_WIDTH(SW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock          (clock),
    .rstn           (rstn),
    .default_sel_in (default_sel_in),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .sel_out        (sel_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .overflow_sticky(overflow_sticky)
  );

  always #5 clock = ~clock;

  // Popping an empty FIFO must never happen.
  always @(negedge clock) begin
    if (rstn === 1'b1) begin
      for (int i = 0; i < BW; i++) begin
        n_cmp++;
        if (dut.w_fifo_pop[i] && dut.r_count[i] == '0) begin
          n_fail++;
          $display("FAIL pop_empty lane %0d t=%0t got pop with count 0 required no pop", i, $time);
        end
      end
    end
  end

  function automatic logic [31:0] lane_tag(int l);
    case (l)
      3:       return TAG_HOT;
      2:       return TAG_WARM;
      1:       return TAG_LUKEWARM;
      default: return default_sel_in;
    endcase
  endfunction

  function automatic int pick();
`ifdef VERTEX_CRITERION_MERGE_FIXED_PRIORITY_EN
    for (int l = 3; l >= 0; l--) if (m_q[l].size() > 0) return l;
`else
    for (int k = 0; k < 4; k++) begin
      int l;
      l = (m_rr + k) % 4;
      if (m_q[l].size() > 0) return l;
    end
`endif
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_q[i].delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = STRUCT_INVALID;
    m_rr    = 0;
    m_ovf   = '0;
  endtask

  // One clock: model update from pre-edge inputs, then compare the DUT 1 ns after the edge.
  task automatic step();
    logic [3:0] push;
    logic [3:0] exp_rdy;
    bit         load;
    int         g;
    for (int i = 0; i < 4; i++) push[i] = data_in_valid[i] && (m_q[i].size() < DEPTH - 1);
    load = !m_valid || data_out_ready;
    @(posedge clock);
    for (int i = 0; i < 4; i++) begin
      if (push[i]) m_q[i].push_back(data_in[i*DW +: DW]);
      else if (data_in_valid[i]) m_ovf[i] = 1'b1;
    end
    if (load) begin
      g = pick();
      if (g >= 0) begin
        m_data  = m_q[g].pop_front();
        m_sel   = lane_tag(g);
        m_valid = 1'b1;
        m_rr    = (g + 1) % 4;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    for (int i = 0; i < 4; i++) exp_rdy[i] = (m_q[i].size() < DEPTH - 1);
    n_cmp++;
    if (data_out_valid !== m_valid) begin
      n_fail++;
      $display("FAIL model_valid t=%0t got %b required %b", $time, data_out_valid, m_valid);
    end
    if (m_valid) begin
      n_cmp++;
      if (data_out !== m_data) begin
        n_fail++;
        $display("FAIL model_data t=%0t got %h required %h", $time, data_out, m_data);
      end
      n_cmp++;
      if (sel_out !== m_sel) begin
        n_fail++;
        $display("FAIL model_sel t=%0t got %h required %h", $time, sel_out, m_sel);
      end
    end
    n_cmp++;
    if (data_in_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL model_ready t=%0t got %b required %b", $time, data_in_ready, exp_rdy);
    end
    n_cmp++;
    if (overflow_sticky !== m_ovf) begin
      n_fail++;
      $display("FAIL model_overflow t=%0t got %b required %b", $time, overflow_sticky, m_ovf);
    end
  endtask

  // Asserts reset away from the clock edge and checks the asynchronous reset values.
  task automatic do_reset();
    data_in_valid = '0;
    rstn = 1'b0;
    #1;
    n_cmp++;
    if (data_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid got %b required 0", data_out_valid);
    end
    n_cmp++;
    if (sel_out !== STRUCT_INVALID) begin
      n_fail++;
      $display("FAIL reset_sel got %h required %h", sel_out, STRUCT_INVALID);
    end
    n_cmp++;
    if (data_out !== '0) begin
      n_fail++;
      $display("FAIL reset_data got %h required 0", data_out);
    end
    n_cmp++;
    if (overflow_sticky !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_overflow got %b required 0000", overflow_sticky);
    end
    n_cmp++;
    if (data_in_ready !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset_ready got %b required 1111", data_in_ready);
    end
    model_clear();
    #3;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn           = 1'b1;
    default_sel_in = 32'h0000_0007;
    data_in        = '0;
    data_in_valid  = '0;
    data_out_ready = 1'b1;
    #2;
    do_reset();
    step();
  endtask

  task automatic test_single_lane2();
    data_in[2*DW +: DW] = 32'hA5A5_A5A5;
    data_in_valid = 4'b0100;
    data_out_ready = 1'b1;
    step();
    data_in_valid = '0;
    n_cmp++;
    if (data_out_valid !== 1'b1 || data_out !== 32'hA5A5_A5A5 || sel_out !== TAG_WARM) begin
      n_fail++;
      $display("FAIL single_beat got v=%b d=%h s=%h required v=1 d=a5a5a5a5 s=%h",
               data_out_valid, data_out, sel_out, TAG_WARM);
    end
    step();
    n_cmp++;
    if (data_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_beat_gone got %b required 0", data_out_valid);
    end
  endtask

  task automatic test_all_lanes();
    int lane;
    do_reset();
    default_sel_in = 32'h0000_0007;
    data_out_ready = 1'b1;
    for (int round = 0; round < 2; round++) begin
      for (int i = 0; i < 4; i++) data_in[i*DW +: DW] = 32'hC0DE_0000 + 32'(round * 16 + i);
      data_in_valid = 4'b1111;
      for (int k = 0; k < 4; k++) begin
        step();
        data_in_valid = '0;
`ifdef VERTEX_CRITERION_MERGE_FIXED_PRIORITY_EN
        lane = 3 - k;
`else
        lane = k;
`endif
        n_cmp++;
        if (data_out_valid !== 1'b1 || data_out !== 32'hC0DE_0000 + 32'(round * 16 + lane)
            || sel_out !== lane_tag(lane)) begin
          n_fail++;
          $display("FAIL all_lanes_order r%0d k%0d got v=%b d=%h s=%h required lane %0d",
                   round, k, data_out_valid, data_out, sel_out, lane);
        end
      end
      step();
      n_cmp++;
      if (data_out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL all_lanes_idle got %b required 0", data_out_valid);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] b [6];
    do_reset();
    data_out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      b[k] = $urandom;
      data_in[1*DW +: DW] = b[k];
      data_in_valid = 4'b0010;
      step();
      if (k == 2) begin
        n_cmp++;
        if (data_in_ready[1] !== 1'b1) begin
          n_fail++;
          $display("FAIL ovf_ready_early got %b required 1", data_in_ready[1]);
        end
      end
      if (k == 3) begin
        n_cmp++;
        if (data_in_ready[1] !== 1'b0) begin
          n_fail++;
          $display("FAIL ovf_ready_fall got %b required 0", data_in_ready[1]);
        end
      end
      if (k == 4) begin
        n_cmp++;
        if (overflow_sticky[1] !== 1'b1) begin
          n_fail++;
          $display("FAIL ovf_sticky got %b required 1", overflow_sticky[1]);
        end
      end
    end
    data_in_valid = '0;
    data_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (data_out_valid !== 1'b1 || data_out !== b[k] || sel_out !== TAG_LUKEWARM) begin
        n_fail++;
        $display("FAIL ovf_drain k%0d got v=%b d=%h s=%h required v=1 d=%h s=%h",
                 k, data_out_valid, data_out, sel_out, b[k], TAG_LUKEWARM);
      end
      step();
    end
    n_cmp++;
    if (data_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_drain_end got %b required 0", data_out_valid);
    end
  endtask

  task automatic test_stall();
    logic [31:0] s [4];
    do_reset();
    data_out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s[k] = $urandom;
      data_in[3*DW +: DW] = s[k];
      data_in_valid = 4'b1000;
      step();
    end
    data_in_valid = '0;
    for (int c = 0; c < 5; c++) begin
      step();
      n_cmp++;
      if (data_out_valid !== 1'b1 || data_out !== s[0] || sel_out !== TAG_HOT) begin
        n_fail++;
        $display("FAIL stall_hold c%0d got v=%b d=%h s=%h required v=1 d=%h s=%h",
                 c, data_out_valid, data_out, sel_out, s[0], TAG_HOT);
      end
      n_cmp++;
      if (data_in_ready[3] !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_count c%0d got ready %b required 0", c, data_in_ready[3]);
      end
    end
    data_out_ready = 1'b1;
    for (int c = 0; c < 5; c++) step();
  endtask

  task automatic test_lane0_sel();
    logic [31:0] v;
    default_sel_in = 32'h0000_0007;
    data_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      v = $urandom;
      data_in[0 +: DW] = v;
      data_in_valid = 4'b0001;
      step();
      n_cmp++;
      if (data_out_valid !== 1'b1 || sel_out !== 32'h0000_0007 || data_out !== v) begin
        n_fail++;
        $display("FAIL lane0_sel k%0d got v=%b d=%h s=%h required v=1 d=%h s=00000007",
                 k, data_out_valid, data_out, sel_out, v);
      end
    end
    data_in_valid = '0;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    data_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      data_in[1*DW +: DW] = $urandom;
      data_in_valid = 4'b0010;
      step();
    end
    data_in_valid = '0;
    data_out_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      step();
      n_cmp++;
      if (data_out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_emit c%0d got %b required 0", c, data_out_valid);
      end
    end
  endtask

  task automatic test_random();
    default_sel_in = $urandom;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) data_in[i*DW +: DW] = $urandom;
      data_in_valid  = 4'($urandom_range(0, 15));
      data_out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    data_in_valid  = '0;
    data_out_ready = 1'b1;
    for (int c = 0; c < 16; c++) step();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single_lane2();
    test_all_lanes();
    test_overflow();
    test_stall();
    test_lane0_sel();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
